// File: rtl/dmem_arb_pkg.sv
// Shared types and the access legality check for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10
  } size_e;

  typedef logic req_idx_t;

  // True when the access must be rejected: bad size code, misaligned, or past the end of memory.
  function automatic logic access_err(input logic [1:0] size, input logic [63:0] addr,
                                      input logic [63:0] limit);
    logic misalign;
    case (size)
      SZ_WORD: misalign = (addr[1:0] != 2'b00);
      SZ_HALF: misalign = addr[0];
      SZ_BYTE: misalign = 1'b0;
      default: misalign = 1'b1;
    endcase
    return misalign || (addr >= limit);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from req and the pointer (zero latency),
// losers simply keep req high; the pointer flips to the other requester after every grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_idx_t ptr_q, ptr_d;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (!reset) begin
      if (req0 && (!req1 || ptr_q == 1'b0)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) ptr_d = 1'b1;
    if (gnt1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two requesters share one combinational data memory; one access per cycle, response one cycle
// after grant. Ungranted requesters hold their request until gnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        size0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,
  output logic              err1,
  output logic              MemWrite,
  output logic [1:0]        ByteAccess,
  output logic [31:0]       ALUResult,
  output logic [31:0]       WriteData,
  input  logic [31:0]       ReadData
);

  localparam logic [63:0] LIMIT = 64'(4 * MEM_WORDS);

  req_idx_t          sel;
  logic              any_gnt;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              acc_err;

  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    sel       = gnt1;
    any_gnt   = gnt0 | gnt1;
    sel_we    = sel ? we1    : we0;
    sel_size  = sel ? size1  : size0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    acc_err   = access_err(sel_size, 64'(sel_addr), LIMIT);

    MemWrite   = any_gnt & sel_we & ~acc_err;
    ByteAccess = any_gnt ? sel_size       : 2'b00;
    ALUResult  = any_gnt ? 32'(sel_addr)  : 32'h0;
    WriteData  = any_gnt ? sel_wdata      : 32'h0;
  end

  always_comb begin
    rvalid_d = 2'b00;
    err_d    = 2'b00;
    rdata_d  = '{default: 32'h0};
    if (any_gnt) begin
      rvalid_d[sel] = 1'b1;
      err_d[sel]    = acc_err;
      rdata_d[sel]  = (acc_err || sel_we) ? 32'h0 : ReadData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= '{default: 32'h0};
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // A response registered just before reset rises is suppressed so it is never seen.
  assign rvalid0 = rvalid_q[0] & ~reset;
  assign rvalid1 = rvalid_q[1] & ~reset;
  assign err0    = err_q[0] & ~reset;
  assign err1    = err_q[1] & ~reset;
  assign rdata0  = reset ? 32'h0 : rdata_q[0];
  assign rdata1  = reset ? 32'h0 : rdata_q[1];

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the shared data memory; byte address limit is 4*MEM_WORDS.
REQ-002 SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have, per requester n in {0,1}, the following ports:
- reqN, input, 1: access request.
- weN, input, 1: write enable.
- sizeN, input, 2: access size, 00 word, 01 byte, 10 half.
- addrN, input, ADDR_W: byte address.
- wdataN, input, 32: store data.
- gntN, output, 1: access accepted this cycle.
- rvalidN, output, 1: response valid.
- rdataN, output, 32: load data.
- errN, output, 1: access rejected.
REQ-006 SHALL have port MemWrite, output, 1: memory write strobe.
REQ-007 SHALL have port ByteAccess, output, 2: memory size code, same encoding as sizeN.
REQ-008 SHALL have port ALUResult, output, 32: memory byte address.
REQ-009 SHALL have port WriteData, output, 32: memory store data.
REQ-010 SHALL have port ReadData, input, 32: combinational memory load data.

Function
REQ-011 SHALL grant at most one requester per cycle. gntN is combinational from reqN and the priority pointer.
REQ-012 SHALL arbitrate round-robin:
- If only one requester has req high, that requester is granted.
- If both have req high, the requester named by the priority pointer is granted.
- After any grant, the pointer moves to the other requester.
REQ-013 Requesters SHALL hold req, we, size, addr and wdata stable until gnt. The arbiter SHALL NOT check this.
REQ-014 During a granted cycle, SHALL drive ALUResult, ByteAccess and WriteData from the granted port, zero-extending addr to 32 bits. MemWrite SHALL equal the granted port's we, masked per REQ-017.
REQ-015 When no requester is granted, SHALL drive MemWrite=0 and ALUResult, ByteAccess, WriteData all zero.
REQ-016 On the clock edge that ends a granted cycle, SHALL register a response for the granted port, so that rvalidN=1 for exactly one cycle on the following cycle:
- A read returns ReadData in rdataN.
- A write returns rdataN=0.
REQ-017 SHALL flag an access as an error in either of these cases:
- Misaligned: a word access with addr[1:0]!=0, or a half access with addr[0]=1.
- Out of range: addr >= 4*MEM_WORDS.
- Size code 11.
REQ-018 For an error access, the arbiter SHALL:
- still grant it;
- force MemWrite=0;
- respond next cycle with rvalidN=1, errN=1, rdataN=0.
errN SHALL be 0 whenever rvalidN is 0.
REQ-019 SHALL allow back-to-back grants: a new grant may occur in the same cycle that rvalid is high for the previous one. Throughput SHALL be one access per cycle.
REQ-020 SHALL cause a read granted in the cycle after a write to the same address to return the newly written data.
REQ-021 When both requesters hold req continuously, SHALL grant them alternately, with no starvation beyond one cycle.

Reset
REQ-022 When reset is high at a clock edge, SHALL set:
- priority pointer to requester 0;
- rvalid0, rvalid1, err0, err1 to 0;
- rdata0, rdata1 to 0.
REQ-023 While reset is high, SHALL hold gnt0, gnt1 and MemWrite at 0, so that no memory write occurs.
REQ-024 If reset is asserted while a response is pending, the response SHALL be dropped and SHALL NOT be delivered after reset releases.
REQ-025 On the first cycle after reset releases, SHALL accept requests.

Structure
REQ-026 SHALL place the following in package dmem_arb_pkg:
- size enum: SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10;
- requester-index typedef;
- the alignment/range-check function.
REQ-027 SHALL implement the priority pointer and grant logic in one sub-module, rr_arb2. The mux, error check and response registers SHALL live in dmem_arbiter.

Verification
REQ-028 Bench SHALL cover: reset, then req0 only, we0=1, size0=00, addr0=0x10, wdata0=0xDEADBEEF.
- Required: gnt0 in the same cycle, with MemWrite=1 and ALUResult=0x10.
- Required: rvalid0=1 with err0=0 on the next cycle.
REQ-029 Bench SHALL cover: req1 only, read, size1=01, addr1=0x12, after the REQ-028 write.
- Required: rdata1=0x000000AD with rvalid1 one cycle after gnt1.
REQ-030 Bench SHALL cover: req0 and req1 both held high for 4 cycles directly after reset.
- Required: grant sequence 0,1,0,1.
- Required: rvalid alternates between the two ports with one-cycle lag.
REQ-031 Bench SHALL cover: req0 write, size=10, addr0=0x21.
- Required: gnt0=1, MemWrite=0, then rvalid0=1, err0=1, rdata0=0.
- Required: memory word 0x20 unchanged.
REQ-032 Bench SHALL cover: req1 read, addr1=0x100 with MEM_WORDS=64.
- Required: err1=1 on the next cycle.
REQ-033 Bench SHALL cover: reset asserted in the cycle after a read grant.
- Required: rvalid stays 0.
- Required: after release, the pointer is at requester 0 (both req high grants port 0 first).
